decoder_5_to_32: RTL and testbench
==================================

Name: decoder_5_to_32

Overview:
- Binary-to-one-hot decoder: 5-bit index in, 32-bit one-hot word out.
- Provides a zero-latency combinational decode plus a registered, enable-gated copy with valid flag and an encode-back checker.
- Used as a select/strobe generator (register-file write enables, bank selects) in datapath control.

Parameters:
- IN_W, 5, index width; legal range 1..6.
- OUT_W, 2**IN_W (32), one-hot width; derived, not overridable.
- ACT_LOW_OUT, 0, when 1 the registered word output_data_q is inverted (one-cold); the combinational output is never inverted.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable for the registered path.
- input_data  input  IN_W  binary index to decode.
- output_data  output  OUT_W  combinational one-hot: bit input_data = 1, all others 0.
- output_data_q  output  OUT_W  registered decode, captured when en = 1.
- out_valid_q  output  1  1 the cycle after a capture; 0 after a cycle with en = 0.
- index_q  output  IN_W  re-encoded index of output_data_q (checker readback).
- err_q  output  1  sticky flag: set if the registered word is ever not exactly one-hot.

Behaviour:
- output_data = 1 << input_data, purely combinational, independent of clk, rst_n and en.
  - Settles within the same delta/evaluation; no latch inferred.
  - Exactly one bit is high for every legal input value 0..31.
  - For any X/Z bit on input_data, output_data is all-X in simulation.
- Registered path, on the rising edge of clk with rst_n = 1:
  - If en = 1: output_data_q <= decode(input_data), XORed with all-ones when ACT_LOW_OUT = 1; out_valid_q <= 1.
  - If en = 0: output_data_q holds its value; out_valid_q <= 0.
  - Latency is 1 cycle from a sampled input to output_data_q.
- index_q: combinational priority encode (lowest set bit) of the non-inverted stored word; 0 when the stored word is all-zero.
- err_q:
  - Sets on any clock edge where the stored non-inverted word has popcount != 1 while out_valid_q = 1.
  - Once set, it clears only on reset.
- Reset (rst_n = 0, asynchronous assert, synchronous-safe deassert):
  - output_data_q = 0 (all-ones if ACT_LOW_OUT = 1).
  - out_valid_q = 0, index_q = 0, err_q = 0.
- Reset mid-operation: registered outputs clear immediately and the combinational output is unaffected.
- Boundaries:
  - input_data = 0 produces bit 0.
  - input_data = 31 produces bit 31, the MSB.
  - Incrementing 31 wraps the index to 0 in the driver; the decoder handles every code with no out-of-range case.

Decomposition:
- Shared package dec_pkg holds:
  - DEC_IN_W = 5 and DEC_OUT_W = 32.
  - typedef dec_idx_t as logic [DEC_IN_W-1:0].
  - typedef dec_onehot_t as logic [DEC_OUT_W-1:0].
  - Pure functions onehot_decode() and onehot_encode().
- One natural sub-module, onehot_encoder_32, provides the index_q readback and the popcount-based one-hot check.

Test Plan:
- Sweep input_data 0..31, checking 10 time units after each change: output_data equals 1 << input_data (e.g. 5 -> 0x0000_0020, 31 -> 0x8000_0000). Any mismatch is a failure.
- Reset check: drive rst_n = 0 mid-clock with en = 1 and input_data = 7. output_data_q = 0, out_valid_q = 0 and err_q = 0 immediately, without waiting for a clock edge. output_data still reads 0x0000_0080.
- Registered latency: en = 1, input_data = 12 at edge N. At edge N+1: output_data_q = 0x0000_1000, out_valid_q = 1, index_q = 12.
- Enable hold: after capturing 3, set en = 0 and input_data = 20. output_data_q stays 0x0000_0008 and out_valid_q drops to 0, while output_data = 0x0010_0000.
- ACT_LOW_OUT = 1 build: capture index 0 -> output_data_q = 0xFFFF_FFFE and index_q = 0. Reset value is 0xFFFF_FFFF.
- Full 32-value registered sweep with en = 1 every cycle: err_q stays 0 and index_q tracks the input delayed by one cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and helpers for the 5-to-32 one-hot decoder and its encode-back checker.
package dec_pkg;

    localparam int DEC_IN_W  = 5;
    localparam int DEC_OUT_W = 32;

    typedef logic [DEC_IN_W-1:0]  dec_idx_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    // Binary index to one-hot word. An X/Z bit in idx makes the shift, and so the
    // whole word, unknown in simulation.
    function automatic dec_onehot_t onehot_decode(input dec_idx_t idx);
        return dec_onehot_t'(1) << idx;
    endfunction

    // Priority encode of the lowest set bit; an all-zero word encodes to 0.
    function automatic dec_idx_t onehot_encode(input dec_onehot_t word);
        dec_idx_t idx;
        idx = '0;
        for (int i = DEC_OUT_W - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = dec_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_encoder_32.sv
// Encode-back checker: re-encodes a one-hot word to its index (lowest set bit wins)
// and flags whether the word holds exactly one set bit.
module onehot_encoder_32
    import dec_pkg::*;
#(
    parameter int IN_W = DEC_IN_W,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic [OUT_W-1:0] word_i,
    output logic [IN_W-1:0]  index_o,
    output logic             onehot_o
);

    // The count must reach OUT_W itself, hence one bit wider than the index.
    localparam int CNT_W = IN_W + 1;

    logic [CNT_W-1:0] cnt;

    if (IN_W == DEC_IN_W) begin : g_pkg_enc
        assign index_o = onehot_encode(word_i);
    end else begin : g_loop_enc
        // Lowest set bit wins: scan from the top so the last hit is the lowest.
        always_comb begin
            index_o = '0;
            for (int i = OUT_W - 1; i >= 0; i--) begin
                if (word_i[i]) begin
                    index_o = IN_W'(i);
                end
            end
        end
    end

    // Population count of the word; exactly one set bit means a valid one-hot.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            cnt = cnt + CNT_W'(word_i[i]);
        end
    end

    assign onehot_o = (cnt == CNT_W'(1));

endmodule

// File: rtl/decoder_5_to_32.sv
// Binary-to-one-hot decoder with a combinational output, an enable-gated registered
// copy (optionally one-cold), a valid flag, and a sticky one-hot integrity flag.
module decoder_5_to_32
    import dec_pkg::*;
#(
    parameter int IN_W        = DEC_IN_W,
    parameter int ACT_LOW_OUT = 0,
    localparam int OUT_W      = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  input_data,
    output logic [OUT_W-1:0] output_data,
    output logic [OUT_W-1:0] output_data_q,
    output logic             out_valid_q,
    output logic [IN_W-1:0]  index_q,
    output logic             err_q
);

    // All-ones when the registered word is one-cold; applied on store and undone on readback.
    localparam logic [OUT_W-1:0] INV_MASK = {OUT_W{(ACT_LOW_OUT != 0)}};

    logic [OUT_W-1:0] dec_w;
    logic [OUT_W-1:0] word_d;
    logic             valid_d;
    logic             err_d;
    logic [OUT_W-1:0] stored_plain;
    logic             onehot_ok;

    if (IN_W == DEC_IN_W) begin : g_pkg_dec
        assign dec_w = onehot_decode(input_data);
    end else begin : g_shift_dec
        assign dec_w = OUT_W'(1) << input_data;
    end

    // The combinational output ignores clock, reset and enable entirely.
    assign output_data = dec_w;

    // Next state: capture the (optionally inverted) decode on enable, otherwise hold the word.
    always_comb begin
        word_d  = output_data_q;
        valid_d = 1'b0;
        if (en) begin
            word_d  = dec_w ^ INV_MASK;
            valid_d = 1'b1;
        end
    end

    // The checker always looks at the non-inverted word.
    assign stored_plain = output_data_q ^ INV_MASK;

    onehot_encoder_32 #(
        .IN_W (IN_W)
    ) u_enc (
        .word_i   (stored_plain),
        .index_o  (index_q),
        .onehot_o (onehot_ok)
    );

    // Sticky: only a word that is claimed valid can raise the error, and only reset clears it.
    assign err_d = err_q | (out_valid_q & ~onehot_ok);

    // Registered decode, valid flag and error flag; reset clears to the idle (non-selecting) word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data_q <= INV_MASK;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            output_data_q <= word_d;
            out_valid_q   <= valid_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_decoder_5_to_32.sv
// Directed bench for decoder_5_to_32: one default instance and one one-cold instance
// share the same stimulus.
module tb_decoder_5_to_32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic [4:0]  input_data = 5'd0;

    logic [31:0] od, odq, od_lo, odq_lo;
    logic        v, v_lo;
    logic [4:0]  iq, iq_lo;
    logic        e, e_lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_5_to_32 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .input_data    (input_data),
        .output_data   (od),
        .output_data_q (odq),
        .out_valid_q   (v),
        .index_q       (iq),
        .err_q         (e)
    );

    decoder_5_to_32 #(
        .ACT_LOW_OUT (1)
    ) dut_lo (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .input_data    (input_data),
        .output_data   (od_lo),
        .output_data_q (odq_lo),
        .out_valid_q   (v_lo),
        .index_q       (iq_lo),
        .err_q         (e_lo)
    );

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++; if (odq !== 32'h0000_0000) begin bad++; $display("FAIL reset_q got=%h want=%h", odq, 32'h0); end
        total++; if (v !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", v); end
        total++; if (iq !== 5'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", iq); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", e); end
        total++; if (odq_lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_q_lo got=%h want=ffffffff", odq_lo); end
        total++; if (iq_lo !== 5'd0) begin bad++; $display("FAIL reset_index_lo got=%0d want=0", iq_lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep();
        logic [31:0] exp;
        en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            input_data = 5'(i);
            exp = 32'h1 << i;
            #10;
            total++;
            if (od !== exp) begin bad++; $display("FAIL comb_sweep[%0d] got=%h want=%h", i, od, exp); end
        end
        input_data = 5'd5;  #10;
        total++; if (od !== 32'h0000_0020) begin bad++; $display("FAIL comb_5 got=%h want=00000020", od); end
        input_data = 5'd31; #10;
        total++; if (od !== 32'h8000_0000) begin bad++; $display("FAIL comb_31 got=%h want=80000000", od); end
        input_data = 5'd0;  #10;
        total++; if (od !== 32'h0000_0001) begin bad++; $display("FAIL comb_0 got=%h want=00000001", od); end
        total++; if (od_lo !== 32'h0000_0001) begin bad++; $display("FAIL comb_0_lo got=%h want=00000001", od_lo); end
        total++; if (odq !== 32'h0000_0000) begin bad++; $display("FAIL comb_no_capture got=%h want=00000000", odq); end
        total++; if (v !== 1'b0) begin bad++; $display("FAIL comb_no_valid got=%b want=0", v); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        en = 1'b1; input_data = 5'd12;
        @(posedge clk); #1;
        total++; if (odq !== 32'h0000_1000) begin bad++; $display("FAIL lat_q got=%h want=00001000", odq); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", v); end
        total++; if (iq !== 5'd12) begin bad++; $display("FAIL lat_index got=%0d want=12", iq); end
        total++; if (odq_lo !== 32'hFFFF_EFFF) begin bad++; $display("FAIL lat_q_lo got=%h want=ffffefff", odq_lo); end
        total++; if (iq_lo !== 5'd12) begin bad++; $display("FAIL lat_index_lo got=%0d want=12", iq_lo); end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        en = 1'b1; input_data = 5'd3;
        @(posedge clk); #1;
        total++; if (odq !== 32'h0000_0008) begin bad++; $display("FAIL hold_capture got=%h want=00000008", odq); end
        @(negedge clk);
        en = 1'b0; input_data = 5'd20;
        @(posedge clk); #1;
        total++; if (odq !== 32'h0000_0008) begin bad++; $display("FAIL hold_q got=%h want=00000008", odq); end
        total++; if (v !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b want=0", v); end
        total++; if (iq !== 5'd3) begin bad++; $display("FAIL hold_index got=%0d want=3", iq); end
        total++; if (od !== 32'h0010_0000) begin bad++; $display("FAIL hold_comb got=%h want=00100000", od); end
        total++; if (odq_lo !== 32'hFFFF_FFF7) begin bad++; $display("FAIL hold_q_lo got=%h want=fffffff7", odq_lo); end
    endtask

    task automatic test_act_low();
        @(negedge clk);
        en = 1'b1; input_data = 5'd0;
        @(posedge clk); #1;
        total++; if (odq_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL actlow_q got=%h want=fffffffe", odq_lo); end
        total++; if (iq_lo !== 5'd0) begin bad++; $display("FAIL actlow_index got=%0d want=0", iq_lo); end
        total++; if (v_lo !== 1'b1) begin bad++; $display("FAIL actlow_valid got=%b want=1", v_lo); end
        total++; if (odq !== 32'h0000_0001) begin bad++; $display("FAIL actlow_plain_q got=%h want=00000001", odq); end
    endtask

    task automatic test_reg_sweep();
        logic [4:0]  idx;
        logic [31:0] exp;
        // 33 steps: the last one wraps the driven index from 31 back to 0.
        for (int k = 0; k <= 32; k++) begin
            idx = 5'(k);
            exp = 32'h1 << idx;
            @(negedge clk);
            en = 1'b1; input_data = idx;
            @(posedge clk); #1;
            total++; if (iq !== idx) begin bad++; $display("FAIL sweep_index[%0d] got=%0d want=%0d", k, iq, idx); end
            total++; if (odq !== exp) begin bad++; $display("FAIL sweep_q[%0d] got=%h want=%h", k, odq, exp); end
            total++; if (odq_lo !== ~exp) begin bad++; $display("FAIL sweep_q_lo[%0d] got=%h want=%h", k, odq_lo, ~exp); end
        end
        @(posedge clk); #1;
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sweep_err got=%b want=0", e); end
        total++; if (e_lo !== 1'b0) begin bad++; $display("FAIL sweep_err_lo got=%b want=0", e_lo); end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        en = 1'b1; input_data = 5'd7;
        @(posedge clk); #1;
        total++; if (v !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", v); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (odq !== 32'h0000_0000) begin bad++; $display("FAIL midrst_q got=%h want=00000000", odq); end
        total++; if (v !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", v); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", e); end
        total++; if (iq !== 5'd0) begin bad++; $display("FAIL midrst_index got=%0d want=0", iq); end
        total++; if (od !== 32'h0000_0080) begin bad++; $display("FAIL midrst_comb got=%h want=00000080", od); end
        total++; if (odq_lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midrst_q_lo got=%h want=ffffffff", odq_lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (odq !== 32'h0000_0080) begin bad++; $display("FAIL midrst_recover got=%h want=00000080", odq); end
        total++; if (iq !== 5'd7) begin bad++; $display("FAIL midrst_recover_index got=%0d want=7", iq); end
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_latency();
        test_enable_hold();
        test_act_low();
        test_reg_sweep();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
